// File: rtl/c3lib_strap_capture.sv
// c3lib_strap_capture
//   Captures static strap values from metal-programmable tie cells after a
//   settle wait. The same value must be seen on two consecutive sample edges
//   before it is accepted. After MAX_RETRY disagreeing sample pairs, the
//   current input is captured anyway and strap_mismatch flags the event.
//   Once the capture completes, software may overwrite strap_out through a
//   valid/ready override port. The block stays in DONE until reset.
//
// Parameters
//   WIDTH       number of strap bits
//   SETTLE_CYC  settle-wait cycles before each sampling attempt (1..255)
//   MAX_RETRY   mismatching sample pairs tolerated before forced capture (1..15)
//
// Ports
//   clk            block clock
//   rst_n          asynchronous active-low reset
//   strap_in       static strap inputs; sampled directly, with no synchronizer
//   ovrd_valid     software override request
//   ovrd_data      override value
//   ovrd_ready     override accepted when high together with ovrd_valid
//                  (decoded from the state flops; high only in DONE)
//   strap_out      captured or overridden strap value
//   strap_done     strap_out valid
//   strap_mismatch sticky flag: at least one sample pair disagreed
module c3lib_strap_capture #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] strap_in,
  input  logic             ovrd_valid,
  input  logic [WIDTH-1:0] ovrd_data,
  output logic             ovrd_ready,
  output logic [WIDTH-1:0] strap_out,
  output logic             strap_done,
  output logic             strap_mismatch
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYC + 1);

  localparam logic [1:0] SETTLE = 2'd0;
  localparam logic [1:0] SAMP_A = 2'd1;
  localparam logic [1:0] SAMP_B = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  // The counter holds the number of settle edges already taken. The edge on
  // which it would reach SETTLE_CYC moves the FSM on and clears it instead,
  // so the counter never wraps.
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [3:0]       RETRY_LAST  = 4'(MAX_RETRY - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] settle_cnt;
  logic [3:0]       retry_cnt;
  logic [WIDTH-1:0] sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= SETTLE;
      settle_cnt     <= '0;
      retry_cnt      <= '0;
      sample         <= '0;
      strap_out      <= '0;
      strap_done     <= 1'b0;
      strap_mismatch <= 1'b0;
    end else begin
      case (state)
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= SAMP_A;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end

        SAMP_A: begin
          sample <= strap_in;
          state  <= SAMP_B;
        end

        SAMP_B: begin
          if (strap_in == sample) begin
            strap_out  <= strap_in;
            strap_done <= 1'b1;
            state      <= DONE;
          end else begin
            strap_mismatch <= 1'b1;
            if (retry_cnt >= RETRY_LAST) begin
              // Retry budget exhausted: capture whatever is present now.
              strap_out  <= strap_in;
              strap_done <= 1'b1;
              state      <= DONE;
            end else begin
              retry_cnt  <= retry_cnt + 4'd1;
              settle_cnt <= '0;
              state      <= SETTLE;
            end
          end
        end

        DONE: begin
          // Terminal until reset. Only an accepted override changes strap_out.
          if (ovrd_valid) begin
            strap_out <= ovrd_data;
          end
        end

        default: begin
          state <= SETTLE;
        end
      endcase
    end
  end

  assign ovrd_ready = (state == DONE);

endmodule

// File: tb/tb_c3lib_strap_capture.sv
// tb_c3lib_strap_capture
//   Directed bench for c3lib_strap_capture at the default parameters.
//   A schedule-based reference model (edge numbers since reset release)
//   predicts every output after each clock edge. Literal checks at key edges
//   pin that model to hand-computed values.
module tb_c3lib_strap_capture;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned SETTLE_CYC = 16;
  localparam int unsigned MAX_RETRY  = 3;
  localparam int          P          = SETTLE_CYC + 2;  // edges per attempt

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] strap_in;
  logic             ovrd_valid;
  logic [WIDTH-1:0] ovrd_data;
  logic             ovrd_ready;
  logic [WIDTH-1:0] strap_out;
  logic             strap_done;
  logic             strap_mismatch;

  c3lib_strap_capture #(
    .WIDTH      (WIDTH),
    .SETTLE_CYC (SETTLE_CYC),
    .MAX_RETRY  (MAX_RETRY)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .strap_in       (strap_in),
    .ovrd_valid     (ovrd_valid),
    .ovrd_data      (ovrd_data),
    .ovrd_ready     (ovrd_ready),
    .strap_out      (strap_out),
    .strap_done     (strap_done),
    .strap_mismatch (strap_mismatch)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int               m_edge;   // edges since release; edge 1 = first with rst_n high
  int               m_base;   // edge number at which the current attempt began
  int               m_fails;  // failed attempts so far
  logic [WIDTH-1:0] m_samp;
  logic [WIDTH-1:0] m_out;
  bit               m_done;
  bit               m_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_edge  = 0;
    m_base  = 0;
    m_fails = 0;
    m_samp  = '0;
    m_out   = '0;
    m_done  = 0;
    m_mis   = 0;
  endtask

  // An attempt spans P edges. Its edge P-1 samples and its edge P compares.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      m_edge++;
      if (m_done) begin
        if (ovrd_valid) m_out = ovrd_data;
      end else if (m_edge - m_base == P - 1) begin
        m_samp = strap_in;
      end else if (m_edge - m_base == P) begin
        if (strap_in == m_samp) begin
          m_done = 1;
          m_out  = strap_in;
        end else begin
          m_mis = 1;
          m_fails++;
          if (m_fails >= MAX_RETRY) begin
            m_done = 1;
            m_out  = strap_in;
          end else begin
            m_base = m_edge;
          end
        end
      end
    end
  endtask

  task automatic compare_model();
    chk("model_strap_out", 32'(strap_out), 32'(m_out));
    chk("model_strap_done", 32'(strap_done), 32'(m_done));
    chk("model_strap_mismatch", 32'(strap_mismatch), 32'(m_mis));
    chk("model_ovrd_ready", 32'(ovrd_ready), 32'(m_done));
  endtask

  // One clock edge: update the model, then check the DUT 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear without a clock.
  // Reset is held through one edge and released mid-cycle, so the next edge
  // is edge 1.
  task automatic async_reset(input string name);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk({name, "_out"}, 32'(strap_out), 32'h0);
    chk({name, "_done"}, 32'(strap_done), 32'h0);
    chk({name, "_mis"}, 32'(strap_mismatch), 32'h0);
    chk({name, "_ready"}, 32'(ovrd_ready), 32'h0);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    strap_in   = 8'hA5;
    ovrd_valid = 1'b0;
    ovrd_data  = '0;
    model_reset();
    #12;
    chk("reset_out", 32'(strap_out), 32'h0);
    chk("reset_done", 32'(strap_done), 32'h0);
    chk("reset_ready", 32'(ovrd_ready), 32'h0);
    step();
    rst_n = 1'b1;

    // Stable 0xA5, with an override attempt at edge 10 that must be ignored
    steps(9);
    ovrd_valid = 1'b1;
    ovrd_data  = 8'h3C;
    step();                                   // edge 10
    chk("ovrd_early_ready", 32'(ovrd_ready), 32'h0);
    chk("ovrd_early_out", 32'(strap_out), 32'h0);
    ovrd_valid = 1'b0;
    steps(7);                                 // edge 17
    chk("stable_e17_done", 32'(strap_done), 32'h0);
    step();                                   // edge 18
    chk("stable_e18_done", 32'(strap_done), 32'h1);
    chk("stable_e18_out", 32'(strap_out), 32'hA5);
    chk("stable_e18_mis", 32'(strap_mismatch), 32'h0);
    chk("stable_e18_ready", 32'(ovrd_ready), 32'h1);

    // Strap changes after DONE do not affect strap_out
    strap_in = 8'h5A;
    steps(20);
    chk("done_hold_out", 32'(strap_out), 32'hA5);

    // Accepted override in DONE
    ovrd_valid = 1'b1;
    ovrd_data  = 8'h3C;
    step();
    ovrd_valid = 1'b0;
    ovrd_data  = 8'h00;
    chk("ovrd_out", 32'(strap_out), 32'h3C);
    chk("ovrd_done", 32'(strap_done), 32'h1);
    chk("ovrd_mis", 32'(strap_mismatch), 32'h0);
    steps(3);
    chk("ovrd_hold", 32'(strap_out), 32'h3C);

    // Reset in DONE clears everything asynchronously
    strap_in = 8'hA5;
    async_reset("rst_done");

    // One glitch during attempt 1's SAMP_B edge -> retry, done at edge 36
    steps(17);
    strap_in = 8'hA4;
    step();                                   // edge 18
    strap_in = 8'hA5;
    chk("glitch_e18_mis", 32'(strap_mismatch), 32'h1);
    chk("glitch_e18_done", 32'(strap_done), 32'h0);
    steps(17);                                // edge 35
    chk("glitch_e35_done", 32'(strap_done), 32'h0);
    step();                                   // edge 36
    chk("glitch_e36_done", 32'(strap_done), 32'h1);
    chk("glitch_e36_out", 32'(strap_out), 32'hA5);
    chk("glitch_e36_mis", 32'(strap_mismatch), 32'h1);

    // Input toggling every cycle -> forced capture at edge 54
    async_reset("rst_toggle");
    for (int k = 1; k <= 54; k++) begin
      strap_in = (k % 2 == 1) ? 8'h00 : 8'hFF;
      step();
      if (k == 53) chk("toggle_e53_done", 32'(strap_done), 32'h0);
    end
    chk("toggle_e54_done", 32'(strap_done), 32'h1);
    chk("toggle_e54_out", 32'(strap_out), 32'hFF);
    chk("toggle_e54_mis", 32'(strap_mismatch), 32'h1);
    steps(4);
    chk("toggle_hold_out", 32'(strap_out), 32'hFF);

    // Reset pulse mid-SETTLE at edge 9 restarts the capture from edge 1
    strap_in = 8'hA5;
    async_reset("rst_pre");
    steps(9);
    async_reset("rst_e9");
    steps(17);
    chk("restart_e17_done", 32'(strap_done), 32'h0);
    step();
    chk("restart_e18_done", 32'(strap_done), 32'h1);
    chk("restart_e18_out", 32'(strap_out), 32'hA5);

    // Reset mid-SAMP_B (between edge 17 and edge 18) aborts the capture
    async_reset("rst_pre2");
    steps(17);
    async_reset("rst_sampb");
    steps(18);
    chk("sampb_restart_done", 32'(strap_done), 32'h1);
    chk("sampb_restart_mis", 32'(strap_mismatch), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
